// File: rtl/fpu_cmp_stage.sv
// Two-stage floating-point compare / min / max pipeline built around fp_cmp.
// Define FPU_CMP_NV_COUNT_EN to add the saturating nv_count output.
`timescale 1ns/1ps

module fp_cmp #(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic [sig_width+exp_width:0] a,
    input  logic [sig_width+exp_width:0] b,
    input  logic                         zctr,
    output logic                         altb,
    output logic                         aeqb,
    output logic                         unordered,
    output logic                         a_snan,
    output logic                         b_snan,
    output logic [sig_width+exp_width:0] z0,
    output logic [sig_width+exp_width:0] z1
);
    localparam int W = sig_width + exp_width + 1;

    logic                 sign_a, sign_b;
    logic [exp_width-1:0] exp_a, exp_b;
    logic [sig_width-1:0] sig_a, sig_b;
    logic [W-2:0]         mag_a, mag_b;
    logic                 a_nan, b_nan;
    logic                 both_zero, mag_lt, mag_eq;
    logic                 tot_lt, tot_eq;
    logic [W-1:0]         canon_nan;

    assign sign_a = a[W-1];
    assign sign_b = b[W-1];
    assign exp_a  = a[sig_width +: exp_width];
    assign exp_b  = b[sig_width +: exp_width];
    assign sig_a  = a[sig_width-1:0];
    assign sig_b  = b[sig_width-1:0];
    assign mag_a  = a[W-2:0];
    assign mag_b  = b[W-2:0];

    assign a_nan  = (&exp_a) && (|sig_a);
    assign b_nan  = (&exp_b) && (|sig_b);
    assign a_snan = a_nan && !sig_a[sig_width-1];
    assign b_snan = b_nan && !sig_b[sig_width-1];
    assign unordered = a_nan || b_nan;

    assign canon_nan = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};

    assign both_zero = (mag_a == '0) && (mag_b == '0);
    assign mag_lt    = mag_a < mag_b;
    assign mag_eq    = mag_a == mag_b;

    // Total order with -0 < +0; negative magnitudes compare in reverse.
    assign tot_lt = (sign_a != sign_b) ? sign_a
                                       : (sign_a ? (!mag_lt && !mag_eq) : mag_lt);
    assign tot_eq = (a == b);

    always_comb begin
        altb = 1'b0;
        aeqb = 1'b0;
        if (!unordered) begin
            if (!zctr && both_zero) begin
                aeqb = 1'b1;
            end else begin
                altb = tot_lt;
                aeqb = tot_eq;
            end
        end
    end

    always_comb begin
        z0 = tot_lt ? a : b;
        z1 = tot_lt ? b : a;
        if (a_nan && b_nan) begin
            z0 = canon_nan;
            z1 = canon_nan;
        end else if (a_nan) begin
            z0 = b;
            z1 = b;
        end else if (b_nan) begin
            z0 = a;
            z1 = a;
        end
    end

endmodule

module fpu_cmp_stage #(
    parameter int sig_width = 23,
    parameter int exp_width = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [sig_width+exp_width:0] rs1,
    input  logic [sig_width+exp_width:0] rs2,
    input  logic [4:0]                   in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [sig_width+exp_width:0] out_result,
    output logic [4:0]                   out_tag,
    output logic [4:0]                   out_fflags
`ifdef FPU_CMP_NV_COUNT_EN
    ,
    output logic [15:0]                  nv_count
`endif
);
    localparam int W = sig_width + exp_width + 1;

    typedef enum logic [2:0] {
        OP_FLE  = 3'b000,
        OP_FLT  = 3'b001,
        OP_FEQ  = 3'b010,
        OP_FMIN = 3'b100,
        OP_FMAX = 3'b101
    } cmp_op_e;

    logic         s1_valid;
    logic [2:0]   s1_op;
    logic [W-1:0] s1_a, s1_b;
    logic [4:0]   s1_tag;
    logic         s2_valid;
    logic         s1_adv, s2_adv;

    logic         altb, aeqb, unordered, a_snan, b_snan;
    logic [W-1:0] z0, z1;
    logic [W-1:0] s2_result;
    logic         s2_nv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign out_valid = s2_valid;

    fp_cmp #(
        .sig_width (sig_width),
        .exp_width (exp_width)
    ) u_fp_cmp (
        .a         (s1_a),
        .b         (s1_b),
        .zctr      (1'b0),
        .altb      (altb),
        .aeqb      (aeqb),
        .unordered (unordered),
        .a_snan    (a_snan),
        .b_snan    (b_snan),
        .z0        (z0),
        .z1        (z1)
    );

    always_comb begin
        s2_result = '0;
        s2_nv     = 1'b0;
        case (s1_op)
            OP_FLE: begin
                s2_result = {{(W-1){1'b0}}, altb || aeqb};
                s2_nv     = unordered;
            end
            OP_FLT: begin
                s2_result = {{(W-1){1'b0}}, altb};
                s2_nv     = unordered;
            end
            OP_FEQ: begin
                s2_result = {{(W-1){1'b0}}, aeqb};
                s2_nv     = a_snan || b_snan;
            end
            OP_FMIN: begin
                s2_result = z0;
                s2_nv     = a_snan || b_snan;
            end
            OP_FMAX: begin
                s2_result = z1;
                s2_nv     = a_snan || b_snan;
            end
            default: ;
        endcase
    end

    // NOTE: payload registers are reset too so the outputs read as zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= op;
                s1_a   <= rs1;
                s1_b   <= rs2;
                s1_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_fflags <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= s2_result;
                out_tag    <= s1_tag;
                out_fflags <= {s2_nv, 4'b0000};
            end
        end
    end

`ifdef FPU_CMP_NV_COUNT_EN
    // A result counts only when it is actually handed off, and a flush wins over that hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nv_count <= '0;
        end else if (s2_valid && out_ready && !flush && out_fflags[4] && (nv_count != 16'hFFFF)) begin
            nv_count <= nv_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_cmp_stage.sv
// Directed bench for fpu_cmp_stage: reset, compare/min/max vectors, back-pressure, flush, mid-stream reset.
`timescale 1ns/1ps

module tb_fpu_cmp_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [4:0]  out_fflags;
`ifdef FPU_CMP_NV_COUNT_EN
    logic [15:0] nv_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    always #5 clk = ~clk;

    fpu_cmp_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_fflags (out_fflags)
`ifdef FPU_CMP_NV_COUNT_EN
        ,
        .nv_count   (nv_count)
`endif
    );

    // Drives one request with out_ready high and waits (bounded) for its result.
    task automatic send_one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t, output logic acc, output logic [31:0] res,
                            output logic [4:0] fl, output logic [4:0] tg, output int lat);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        #1 acc = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        res = out_result;
        fl  = out_fflags;
        tg  = out_tag;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs1 = '0; rs2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        total++; if (out_fflags !== 5'h0) begin bad++; $display("FAIL reset_out_fflags: got %b want 0", out_fflags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_flush_in_ready: got %b want 0", in_ready); end
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_compare_ops;
        vec_t        v[$];
        logic        acc;
        logic [31:0] res;
        logic [4:0]  fl, tg;
        int          lat;
        v.push_back('{"feq_m0_p0",   3'b010, 32'h80000000, 32'h00000000, 32'h00000001, 5'b00000});
        v.push_back('{"fmax_m0_p0",  3'b101, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000});
        v.push_back('{"fmin_m0_p0",  3'b100, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000});
        v.push_back('{"fmin_snan",   3'b100, 32'h7f800001, 32'h3f800000, 32'h3f800000, 5'b10000});
        v.push_back('{"fmax_2qnan",  3'b101, 32'h7fc00001, 32'h7fc00001, 32'h7fc00000, 5'b00000});
        v.push_back('{"flt_qnan",    3'b001, 32'h7fc00000, 32'h3f800000, 32'h00000000, 5'b10000});
        v.push_back('{"feq_qnan",    3'b010, 32'h7fc00000, 32'h3f800000, 32'h00000000, 5'b00000});
        v.push_back('{"feq_snan",    3'b010, 32'h3f800000, 32'h7f800001, 32'h00000000, 5'b10000});
        v.push_back('{"fle_less",    3'b000, 32'h3f800000, 32'h40000000, 32'h00000001, 5'b00000});
        v.push_back('{"fle_equal",   3'b000, 32'h40000000, 32'h40000000, 32'h00000001, 5'b00000});
        v.push_back('{"flt_equal",   3'b001, 32'h40000000, 32'h40000000, 32'h00000000, 5'b00000});
        v.push_back('{"flt_neg_pos", 3'b001, 32'hbf800000, 32'h3f800000, 32'h00000001, 5'b00000});
        v.push_back('{"flt_greater", 3'b001, 32'h40000000, 32'h3f800000, 32'h00000000, 5'b00000});
        v.push_back('{"fle_m0_p0",   3'b000, 32'h80000000, 32'h00000000, 32'h00000001, 5'b00000});
        v.push_back('{"flt_m0_p0",   3'b001, 32'h80000000, 32'h00000000, 32'h00000000, 5'b00000});
        v.push_back('{"fmin_negs",   3'b100, 32'hbf800000, 32'hc0000000, 32'hc0000000, 5'b00000});
        v.push_back('{"fmax_negs",   3'b101, 32'hbf800000, 32'hc0000000, 32'hbf800000, 5'b00000});
        v.push_back('{"fmax_snan_b", 3'b101, 32'h3f800000, 32'hff800001, 32'h3f800000, 5'b10000});
        v.push_back('{"fmin_ninf",   3'b100, 32'hff800000, 32'h3f800000, 32'hff800000, 5'b00000});
        v.push_back('{"rsvd_011",    3'b011, 32'h3f800000, 32'h40000000, 32'h00000000, 5'b00000});
        v.push_back('{"rsvd_111",    3'b111, 32'h7f800001, 32'h40000000, 32'h00000000, 5'b00000});
        foreach (v[i]) begin
            send_one(v[i].op, v[i].a, v[i].b, 5'(i + 1), acc, res, fl, tg, lat);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL %s accept: got %b want 1", v[i].name, acc); end
            total++; if (lat != 2) begin bad++; $display("FAIL %s latency: got %0d want 2", v[i].name, lat); end
            total++; if (res !== v[i].res) begin bad++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].res); end
            total++; if (fl !== v[i].flags) begin bad++; $display("FAIL %s fflags: got %b want %b", v[i].name, fl, v[i].flags); end
            total++; if (tg !== 5'(i + 1)) begin bad++; $display("FAIL %s tag: got %0d want %0d", v[i].name, tg, i + 1); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] bv[4];
        logic [31:0] ev[4];
        logic [4:0]  tg_s;
        logic [31:0] res_s;
        logic        ir, ov;
        int          sent = 0;
        int          got  = 0;
        bv = '{32'h40000000, 32'hbf800000, 32'h00000000, 32'h7fc00000};
        ev = '{32'h3f800000, 32'hbf800000, 32'h00000000, 32'h3f800000};
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 4);
            if (sent < 4) begin
                op = 3'b100; rs1 = 32'h3f800000; rs2 = bv[sent]; in_tag = 5'(10 + sent);
            end
            out_ready = (cyc >= 3);
            #1;
            ir = in_ready; ov = out_valid; tg_s = out_tag; res_s = out_result;
            if (cyc == 2) begin
                total++; if (ir !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready: got %b want 0", ir); end
                total++; if (sent != 2) begin bad++; $display("FAIL b2b_absorbed: got %0d want 2", sent); end
                total++; if (ov !== 1'b1 || tg_s !== 5'd10) begin bad++; $display("FAIL b2b_hold: got v=%b tag=%0d want v=1 tag=10", ov, tg_s); end
            end
            @(posedge clk);
            if (in_valid && ir) sent++;
            if (ov && out_ready) begin
                total++; if (tg_s !== 5'(10 + got)) begin bad++; $display("FAIL b2b_tag%0d: got %0d want %0d", got, tg_s, 10 + got); end
                total++; if (res_s !== ev[got]) begin bad++; $display("FAIL b2b_result%0d: got %h want %h", got, res_s, ev[got]); end
                got++;
            end
        end
        #1 in_valid = 1'b0;
        total++; if (got != 4) begin bad++; $display("FAIL b2b_received: got %0d want 4", got); end
        total++; if (sent != 4) begin bad++; $display("FAIL b2b_sent: got %0d want 4", sent); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'b101; rs1 = 32'h40000000; rs2 = 32'h3f800000; in_tag = 5'(20 + i);
        end
        @(negedge clk);
        in_tag = 5'd22; flush = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_full: got %b want 1", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = 3'b101; rs1 = 32'h40000000; rs2 = 32'h3f800000; in_tag = 5'(7 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h40000000) begin
            bad++; $display("FAIL rstmid_pre: got v=%b res=%h want v=1 res=40000000", out_valid, out_result);
        end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rstmid_out_result: got %h want 0", out_result); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL rstmid_out_tag: got %0d want 0", out_tag); end
        total++; if (out_fflags !== 5'h0) begin bad++; $display("FAIL rstmid_out_fflags: got %b want 0", out_fflags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_partial: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_compare_ops();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
